// File: rtl/stage_pkg.sv
// Shared types and defaults for the stage arbiter and its round-robin picker.
package stage_pkg;

  localparam int unsigned NREQ_DEF     = 4;
  localparam int unsigned HOLD_MAX_DEF = 8;
  localparam int unsigned CNT_W        = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after (last+1) mod NREQ.
module rr_pick
  import stage_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  int unsigned idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(last) + i) % NREQ;
      if (!any && req[IDW'(idx)]) begin
        any    = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/stage_arbiter.sv
// Round-robin arbiter granting one requester at a time to a shared resource,
// with bounded hold time and a one-cycle result pulse at release.
module stage_arbiter
  import stage_pkg::*;
#(
  parameter  int unsigned NREQ     = NREQ_DEF,
  parameter  int unsigned HOLD_MAX = HOLD_MAX_DEF,
  localparam int unsigned IDW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_gossamer,
  input  logic [NREQ-1:0]   req_city,
  output logic [NREQ-1:0]   grant,
  output logic              m_disconnection,
  output logic [1:0]        m_gossamer,
  output logic              m_two_guitars,
  input  logic              m_nothing_of_note,
  output logic              result_valid,
  output logic [IDW-1:0]    result_id,
  output logic              result_data
);

  state_t            state_q, state_d;
  logic [IDW-1:0]    win_q, win_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   grant_d;
  logic              disc_d;
  logic [1:0]        gos_d;
  logic              tg_d;
  logic              rv_d;
  logic [IDW-1:0]    rid_d;
  logic              rdata_d;
  logic              go_release;

  logic [IDW-1:0]    pick;
  logic              pick_any;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick),
    .any    (pick_any)
  );

  // Next-state and next-output logic; outputs reflect the state being entered.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    grant_d    = grant;
    disc_d     = m_disconnection;
    gos_d      = m_gossamer;
    tg_d       = m_two_guitars;
    rv_d       = 1'b0;
    rid_d      = result_id;
    rdata_d    = result_data;
    go_release = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          win_d   = pick;
          grant_d = NREQ'(1) << pick;
          disc_d  = 1'b0;
          gos_d   = req_gossamer[{pick, 1'b0} +: 2];
          tg_d    = req_city[pick];
        end
      end
      GRANT: begin
        if (!req[win_q]) begin
          go_release = 1'b1;
        end else begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (!req[win_q] || cnt_q == CNT_W'(HOLD_MAX - 1)) begin
          go_release = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Resource output is sampled while still connected, just before disconnect.
    if (go_release) begin
      state_d = RELEASE;
      grant_d = '0;
      disc_d  = 1'b1;
      rv_d    = 1'b1;
      rid_d   = win_q;
      rdata_d = m_nothing_of_note;
      last_d  = win_q;
    end
  end

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      state_q         <= IDLE;
      win_q           <= '0;
      last_q          <= IDW'(NREQ - 1);
      cnt_q           <= '0;
      grant           <= '0;
      m_disconnection <= 1'b1;
      m_gossamer      <= 2'b00;
      m_two_guitars   <= 1'b0;
      result_valid    <= 1'b0;
      result_id       <= '0;
      result_data     <= 1'b0;
    end else begin
      state_q         <= state_d;
      win_q           <= win_d;
      last_q          <= last_d;
      cnt_q           <= cnt_d;
      grant           <= grant_d;
      m_disconnection <= disc_d;
      m_gossamer      <= gos_d;
      m_two_guitars   <= tg_d;
      result_valid    <= rv_d;
      result_id       <= rid_d;
      result_data     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_stage_arbiter.sv
// Bench for stage_arbiter: directed scenarios plus random traffic against a
// transaction-level model of ownership, hold time and release results.
module tb_stage_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned HOLD_MAX = 8;
  localparam int unsigned OW       = 12;

  logic            clk = 1'b0;
  logic            resetb;
  logic [3:0]      req;
  logic [7:0]      req_gossamer;
  logic [3:0]      req_city;
  logic            m_nothing_of_note;
  logic [3:0]      grant;
  logic            m_disconnection;
  logic [1:0]      m_gossamer;
  logic            m_two_guitars;
  logic            result_valid;
  logic [1:0]      result_id;
  logic            result_data;

  int npass = 0;
  int ntotal = 0;

  // Model: who owns the resource, for how many cycles, and the last result.
  int         m_owner;
  int         m_age;
  int         m_last;
  bit         m_rel;
  logic [1:0] m_gos;
  logic       m_tg;
  logic [1:0] m_rid;
  logic       m_rdata;

  always #5 clk = ~clk;

  stage_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
    .clk               (clk),
    .resetb            (resetb),
    .req               (req),
    .req_gossamer      (req_gossamer),
    .req_city          (req_city),
    .grant             (grant),
    .m_disconnection   (m_disconnection),
    .m_gossamer        (m_gossamer),
    .m_two_guitars     (m_two_guitars),
    .m_nothing_of_note (m_nothing_of_note),
    .result_valid      (result_valid),
    .result_id         (result_id),
    .result_data       (result_data)
  );

  function automatic logic [OW-1:0] obs();
    return {grant, m_disconnection, m_gossamer, m_two_guitars,
            result_valid, result_id, result_data};
  endfunction

  function automatic logic [OW-1:0] expv();
    logic [3:0] g;
    logic [1:0] o;
    o = m_owner[1:0];
    g = (m_owner >= 0) ? (4'b0001 << o) : 4'b0000;
    return {g, (m_owner < 0), m_gos, m_tg, m_rel, m_rid, m_rdata};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_last = NREQ - 1; m_rel = 0;
    m_gos = 2'b00; m_tg = 1'b0; m_rid = 2'b00; m_rdata = 1'b0;
  endtask

  // A grant lives at most 1 + HOLD_MAX cycles; one free cycle follows a release.
  task automatic model_step();
    bit   prev_rel;
    logic [1:0] o;
    prev_rel = m_rel;
    m_rel = 0;
    o = m_owner[1:0];
    if (m_owner >= 0) begin
      if (!req[o] || m_age == int'(HOLD_MAX) + 1) begin
        m_rel = 1; m_rid = o; m_rdata = m_nothing_of_note;
        m_last = m_owner; m_owner = -1;
      end else begin
        m_age++;
      end
    end else if (!prev_rel && req != 4'b0000) begin
      for (int k = 1; k <= int'(NREQ); k++) begin
        int idx;
        idx = (m_last + k) % NREQ;
        if (req[idx[1:0]]) begin
          m_owner = idx;
          break;
        end
      end
      o = m_owner[1:0];
      m_age = 1;
      m_gos = req_gossamer[{o, 1'b0} +: 2];
      m_tg  = req_city[o];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000; req_gossamer = 8'h00; req_city = 4'b0000; m_nothing_of_note = 1'b0;
    resetb = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetb = 1'b0;
  endtask

  task automatic test_reset();
    resetb = 1'b1;
    req = 4'b0000; req_gossamer = 8'h00; req_city = 4'b0000; m_nothing_of_note = 1'b0;
    model_reset();
    #2;
    ntotal++;
    if (obs() !== 12'b0000_1_00_0_0_00_0)
      $display("FAIL reset_values got=%b want=%b", obs(), 12'b0000_1_00_0_0_00_0);
    else npass++;
    repeat (2) @(posedge clk);
    #1;
    resetb = 1'b0;
    repeat (2) begin
      step();
      ntotal++;
      if (obs() !== expv()) $display("FAIL idle_quiet got=%b want=%b", obs(), expv());
      else npass++;
    end
  endtask

  task automatic test_basic();
    do_reset();
    req = 4'b0101;
    step();
    ntotal++;
    if (grant !== 4'b0001) $display("FAIL first_grant got=%b want=0001", grant);
    else npass++;
    repeat (2) step();
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      ntotal++;
      if (obs() !== expv()) $display("FAIL basic_seq cyc=%0d got=%b want=%b", i, obs(), expv());
      else npass++;
    end
    ntotal++;
    if (grant !== 4'b0100) $display("FAIL second_grant got=%b want=0100", grant);
    else npass++;
  endtask

  task automatic test_rotation();
    logic [3:0] seen[$];
    logic [3:0] want[5];
    logic [3:0] prev;
    int run;
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    prev = 4'b0000;
    run = 0;
    for (int i = 0; i < 56; i++) begin
      step();
      ntotal++;
      if (obs() !== expv()) $display("FAIL rotation cyc=%0d got=%b want=%b", i, obs(), expv());
      else npass++;
      if (grant != 4'b0000 && prev == 4'b0000) seen.push_back(grant);
      if (grant != 4'b0000) run++;
      if (grant == 4'b0000 && prev != 4'b0000) begin
        ntotal++;
        if (run != int'(HOLD_MAX) + 1) $display("FAIL grant_length got=%0d want=%0d", run, HOLD_MAX + 1);
        else npass++;
        run = 0;
      end
      prev = grant;
    end
    ntotal++;
    if (seen.size() < 5) $display("FAIL rotation_count got=%0d want=5", seen.size());
    else begin
      npass++;
      for (int k = 0; k < 5; k++) begin
        ntotal++;
        if (seen[k] !== want[k]) $display("FAIL rotation_order k=%0d got=%b want=%b", k, seen[k], want[k]);
        else npass++;
      end
    end
  endtask

  task automatic test_config_hold();
    do_reset();
    req = 4'b0100; req_gossamer = 8'b00_10_00_00; req_city = 4'b0100;
    step();
    step();
    req_gossamer = 8'b00_01_00_00; req_city = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step();
      if (grant == 4'b0000) break;
      ntotal++;
      if (m_gossamer !== 2'b10 || m_two_guitars !== 1'b1)
        $display("FAIL config_hold cyc=%0d got=%b%b want=101", i, m_gossamer, m_two_guitars);
      else npass++;
    end
    ntotal++;
    if (obs() !== expv()) $display("FAIL config_release got=%b want=%b", obs(), expv());
    else npass++;
  endtask

  task automatic test_result();
    do_reset();
    req = 4'b1000;
    repeat (3) step();
    req = 4'b0000; m_nothing_of_note = 1'b1;
    step();
    m_nothing_of_note = 1'b0;
    ntotal++;
    if ({result_valid, result_id, result_data} !== 4'b1_11_1)
      $display("FAIL result_pulse got=%b want=1111", {result_valid, result_id, result_data});
    else npass++;
    step();
    ntotal++;
    if (result_valid !== 1'b0) $display("FAIL result_one_cycle got=%b want=0", result_valid);
    else npass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010;
    repeat (6) step();
    #2;
    resetb = 1'b1;
    model_reset();
    #1;
    ntotal++;
    if ({grant, m_disconnection, result_valid} !== 6'b0000_1_0)
      $display("FAIL reset_mid got=%b want=000010", {grant, m_disconnection, result_valid});
    else npass++;
    @(posedge clk);
    #1;
    ntotal++;
    if (obs() !== 12'b0000_1_00_0_0_00_0) $display("FAIL reset_mid_hold got=%b want=%b", obs(), 12'b0000_1_00_0_0_00_0);
    else npass++;
    resetb = 1'b0;
    req = 4'b0000;
  endtask

  task automatic test_drop_in_grant();
    do_reset();
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    ntotal++;
    if ({grant, m_disconnection, result_valid, result_id} !== 8'b0000_1_1_01)
      $display("FAIL drop_in_grant got=%b want=00001101", {grant, m_disconnection, result_valid, result_id});
    else npass++;
    step();
    ntotal++;
    if (obs() !== expv()) $display("FAIL drop_after got=%b want=%b", obs(), expv());
    else npass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      req_gossamer = 8'($urandom);
      req_city = 4'($urandom);
      m_nothing_of_note = 1'($urandom);
      step();
      ntotal++;
      if (obs() !== expv()) $display("FAIL random cyc=%0d req=%b got=%b want=%b", i, req, obs(), expv());
      else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_config_hold();
    test_result();
    test_reset_mid();
    test_drop_in_grant();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/stage_arbiter.md
STAGE_ARBITER -- requirements
Module: stage_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters; legal range 2..8.
REQ-002 Parameter: HOLD_MAX, 8, maximum HOLD cycles per grant; legal range 1..255.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: resetb  in  1  asynchronous, active-high reset.
REQ-005 Port: req  in  NREQ  per-requester access request, level.
REQ-006 Port: req_gossamer  in  2*NREQ  per-requester 2-bit configuration; bits [2i+1:2i] belong to requester i.
REQ-007 Port: req_city  in  NREQ  per-requester two_guitars control bit.
REQ-008 Port: grant  out  NREQ  one-hot grant, registered.
REQ-009 Port: m_disconnection  out  1  shared-resource disconnect control.
REQ-010 Port: m_gossamer  out  2  shared-resource configuration.
REQ-011 Port: m_two_guitars  out  1  shared-resource control bit.
REQ-012 Port: m_nothing_of_note  in  1  shared-resource output.
REQ-013 Port: result_valid  out  1  one-cycle pulse indicating that result_id and result_data are valid.
REQ-014 Port: result_id  out  $clog2(NREQ)  index of the requester that owned the completed grant.
REQ-015 Port: result_data  out  1  value of m_nothing_of_note sampled at release.

Function
REQ-016 FSM states: IDLE, GRANT, HOLD, RELEASE.
REQ-017 In IDLE with req != 0, the arbiter shall select a winner round-robin, starting the search at index (last+1) mod NREQ, and move to GRANT.
REQ-018 In IDLE with req == 0, the FSM shall stay in IDLE and hold all outputs at their idle values.
REQ-019 On entry to GRANT, the arbiter shall set grant to one-hot(winner) and latch req_gossamer[winner] and req_city[winner] into m_gossamer and m_two_guitars.
REQ-020 m_disconnection shall be 0 in GRANT and HOLD, and 1 in IDLE and RELEASE.
REQ-021 GRANT shall last exactly one cycle, then go to HOLD with the hold counter cleared to 0.
REQ-022 HOLD shall increment the counter each cycle and go to RELEASE when req[winner] == 0 or the counter reaches HOLD_MAX-1, whichever occurs first.
REQ-023 If req[winner] drops while in GRANT, the FSM shall go directly to RELEASE.
REQ-024 RELEASE shall last exactly one cycle and shall: clear grant; register result_data = m_nothing_of_note; set result_id = winner; pulse result_valid for one cycle; set last = winner; return to IDLE.
REQ-025 Latency from req asserted in IDLE to grant asserted shall be 1 cycle.
REQ-026 The minimum spacing between two grants shall be 3 cycles (RELEASE, IDLE, GRANT), so grant shall never be high in consecutive grants without a gap.
REQ-027 m_gossamer and m_two_guitars shall not change between GRANT entry and RELEASE, even if the requester's inputs change.
REQ-028 Requests from non-winners arriving during a grant shall be ignored until the next IDLE and shall not be lost while they remain asserted.
REQ-029 The counter shall be 8 bits wide, shall saturate (never wrap), and shall be compared against HOLD_MAX-1.
REQ-030 grant shall be one-hot or zero at every cycle.
REQ-031 With a single persistent requester, it shall be re-granted after every IDLE cycle.

Reset
REQ-032 Asserting resetb shall immediately, regardless of clk, force: state = IDLE; grant = 0; m_disconnection = 1; m_gossamer = 0; m_two_guitars = 0; result_valid = 0; result_id = 0; result_data = 0; counter = 0; last = NREQ-1, so requester 0 wins first after reset.
REQ-033 Reset asserted mid-grant shall abort the grant and shall produce no result_valid pulse.

Structure
REQ-034 The FSM state enum and the default values of NREQ and HOLD_MAX shall be defined in the shared package stage_pkg.
REQ-035 Round-robin selection shall be implemented in the combinational sub-module rr_pick, with inputs req and last and outputs winner and any.

Verification
REQ-036 Reset release with req=4'b0101 -> grant=4'b0001 one cycle later; after release of requester 0, grant=4'b0100 at the next GRANT.
REQ-037 req=4'b1111 held constant -> grant sequence 0001, 0100... shall instead be the rotation 0001, 0010, 0100, 1000, 0001, with 3-cycle gaps and timeout releases at HOLD_MAX=8.
REQ-038 Requester 2 holds req with gossamer=2'b10 and city=1 while its input changes to 2'b01 during HOLD -> m_gossamer stays 2'b10 until RELEASE.
REQ-039 m_nothing_of_note=1 at RELEASE for requester 3 -> result_valid pulses for one cycle with result_id=3 and result_data=1.
REQ-040 resetb asserted during HOLD at counter=4 -> grant=0 and m_disconnection=1 immediately, with no result_valid pulse.
REQ-041 Requester 1 drops req in the GRANT cycle -> RELEASE on the next cycle and HOLD is skipped.
